confreg_mc: RTL and testbench
=============================

# confreg_mc

Multi-channel configuration register block on the CPU's SRAM-like peripheral bus. It generalises the board config-register file in four ways: LED/seven-segment channel count is a parameter, writes honour per-byte enables, a virtual-UART TX FIFO has a ready/valid drain port, and an optional free-running timer register is available. All seven-segment scanning runs internally.

## Interface
- `LED_CH`, default 2: number of LED registers and seven-segment displays (1..8).
- `FIFO_DEPTH`, default 16: VUART TX FIFO depth; must be a power of 2, range 2..128.
- `SCAN_DIV`, default 50000: clock cycles per seven-segment digit slot (≥1).
- `clk  in  1`: the single clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `conf_en  in  1`: access strobe.
- `conf_wen  in  4`: byte write enables; a value of 0 means read.
- `conf_addr  in  32`: byte address; only `[15:0]` is decoded.
- `conf_wdata  in  32`: write data.
- `conf_rdata  out  32`: registered read data.
- `switch  in  8`: push-switch levels.
- `switch_dip  in  8`: DIP-switch levels.
- `led  out  16*LED_CH`: `led[16i+15:16i]` is `led_reg[i][15:0]`.
- `seg_a_g  out  7*LED_CH`: per-channel segments, active-high, bit6 = a … bit0 = g.
- `seg_sel  out  4*LED_CH`: per-channel digit select, one-hot, active-high.
- `uart_tx_valid  out  1`: FIFO is non-empty.
- `uart_tx_data  out  8`: FIFO head byte (show-ahead).
- `uart_tx_ready  in  1`: consumer accepts the head byte.

## Operation
- **Address map** (on `conf_addr[15:0]`):
  - `0x0000+4i`, i < LED_CH: `led_reg[i]`, read/write.
  - `0x0040`: NUM, read/write.
  - `0x0044`: `{24'd0, switch}`, read-only.
  - `0x0048`: `{24'd0, switch_dip}`, read-only.
  - `0x004C`: VUART_DATA, write-only; reads return 0.
  - `0x0050`: VUART_STAT.
  - `0x0054`: TIMER (see Configuration).
  - Any other address reads 0; writes to it are ignored.
- **Writes** occur when `conf_en && conf_wen!=0`. For read/write registers, byte k is updated only if `conf_wen[k]`. Writes to read-only addresses are ignored.
- **VUART_DATA write** with `conf_wen[0]=1` pushes `conf_wdata[7:0]`. If `conf_wen[0]=0`, nothing is pushed.
- **VUART_STAT** layout:
  - bit0: empty.
  - bit1: full.
  - bits[15:8]: count.
  - bit16: overflow, sticky.
  - Other bits read 0.
  - Writing with `conf_wen[2]=1` and `conf_wdata[16]=1` clears overflow.
- **FIFO behaviour:**
  - A push when full and no pop in the same cycle drops the byte and sets overflow.
  - A push when full with a pop in the same cycle is accepted; count is unchanged.
  - A pop occurs when `uart_tx_valid && uart_tx_ready`.
  - Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - If an overflow-clear and a new overflow happen in the same cycle, overflow ends up set.
- **Seven-segment scanning:**
  - A shared counter runs 0..SCAN_DIV-1. On wrap, a shared 2-bit digit index d advances 0→1→2→3→0.
  - Every channel shows hex digit `led_reg[i][4d+3:4d]`, with `seg_sel` bit d = 1.
  - Hex decode (a..g), per nibble:
    - 0: 1111110
    - 1: 0110000
    - 2: 1101101
    - 3: 1111001
    - 4: 0110011
    - 5: 1011011
    - 6: 1011111
    - 7: 1110000
    - 8: 1111111
    - 9: 1111011
    - A: 1110111
    - b: 0011111
    - C: 1001110
    - d: 0111101
    - E: 1001111
    - F: 1000111

## Timing
- **Reset** sets:
  - every `led_reg`, NUM, TIMER, `conf_rdata` and overflow to 0;
  - the FIFO to empty, so `uart_tx_valid=0` and `uart_tx_data=0`;
  - the scan counter to 0 and d to 0, so every `seg_sel`=0001 and every `seg_a_g`=1111110.
- Reset asserted mid-operation discards FIFO contents immediately.
- **Read latency is 1.** `conf_rdata` loads the decoded value on the edge where `conf_en=1`; it holds its value while `conf_en=0`.
- A read and write to the same address in the same cycle returns the pre-write value.
- Register writes are visible on `led` and on subsequent reads from the next edge onward.
- A pushed byte raises `uart_tx_valid` and appears on `uart_tx_data` from the edge that performs the push. With a pop in the same cycle, the head advances and count is unchanged.
- A status read returns the state before that cycle's push/pop.
- `seg_sel`/`seg_a_g` are registered and change one cycle after the scan counter wraps, or one cycle after an `led_reg` write.

## Configuration
- **`CONFREG_TIMER_EN` defined:**
  - TIMER is a 32-bit register incremented every cycle, wrapping at 0xFFFFFFFF→0.
  - A byte-enabled write takes priority over the increment; the written value holds for that edge, and incrementing resumes from the next edge.
  - Reads return the current value.
- **`CONFREG_TIMER_EN` undefined:** no counter is built; `0x0054` reads 0 and writes are ignored.

## Test plan
- **Reset check:** assert `rst` asynchronously mid-cycle → all outputs take their reset values before the next edge; `seg_a_g` is 1111110 on every channel.
- **Byte-enable write:** write 0xAABBCCDD to `0x0004` with `conf_wen=4'b0101`, after `led_reg[1]`=0 → read returns 0x00BB00DD one cycle after the read strobe; `led[31:16]`=0x00DD.
- **FIFO fill and overflow:** push 17 bytes 0x01..0x11 with `uart_tx_ready=0` and FIFO_DEPTH=16 → STAT reads 0x00011002 (count 16, full, overflow). Then hold ready=1 → 0x01..0x10 drain one per cycle, `uart_tx_valid` drops after 16 cycles, and STAT reads 0x00010001.
- **Push/pop when full:** with the FIFO full and ready=1, push 0x55 → count stays 16, overflow is not set, and 0x55 is the last byte drained.
- **Scanning:** SCAN_DIV=4, `led_reg[0]`=0x12A8 → `seg_sel_0` cycles 0001,0010,0100,1000 every 4 cycles while `seg_a_g_0` shows 8,A,2,1 = 1111111, 1110111, 1101101, 0110000.
- **Timer, with `CONFREG_TIMER_EN`:** write 0xFFFFFFFE → reads on the following cycles return 0xFFFFFFFF, 0x00000000, 0x00000001. Without the macro → reads return 0.

Source files
------------

// File: rtl/confreg_mc.sv
// confreg_mc: multi-channel configuration register block on the SRAM-like
// peripheral bus.
//   Bus:     conf_en / conf_wen[3:0] / conf_addr / conf_wdata -> conf_rdata
//            (one-cycle registered read; conf_wen == 0 means read)
//   Inputs:  switch, switch_dip (read-only level registers)
//   Display: led[16*LED_CH], seg_a_g[7*LED_CH], seg_sel[4*LED_CH]
//   VUART:   uart_tx_valid / uart_tx_data / uart_tx_ready (show-ahead drain)
// Optional: define CONFREG_TIMER_EN to build the free-running TIMER at 0x0054.
module confreg_mc #(
    parameter int LED_CH     = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  conf_en,
    input  logic [3:0]            conf_wen,
    input  logic [31:0]           conf_addr,
    input  logic [31:0]           conf_wdata,
    output logic [31:0]           conf_rdata,
    input  logic [7:0]            switch,
    input  logic [7:0]            switch_dip,
    output logic [16*LED_CH-1:0]  led,
    output logic [7*LED_CH-1:0]   seg_a_g,
    output logic [4*LED_CH-1:0]   seg_sel,
    output logic                  uart_tx_valid,
    output logic [7:0]            uart_tx_data,
    input  logic                  uart_tx_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [15:0] addr;
    logic        wr;
    logic        unused_addr;
    assign addr        = conf_addr[15:0];
    assign wr          = conf_en && (conf_wen != 4'd0);
    assign unused_addr = ^conf_addr[31:16];

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int unsigned k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1111110;  4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;  4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;  4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;  4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;  4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;  default: hex7 = 7'b1000111;
        endcase
    endfunction

    // ---------------- registers ----------------
    logic [31:0] led_reg [LED_CH];
    logic [31:0] num_reg;
    logic [31:0] timer_val;
    logic [LED_CH-1:0] led_we;

    always_comb begin
        led_we = '0;
        for (int unsigned i = 0; i < LED_CH; i++)
            if (wr && addr[15:6] == 10'd0 && addr[1:0] == 2'd0 && addr[5:2] == 4'(i))
                led_we[i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LED_CH; i++) led_reg[i] <= '0;
            num_reg <= '0;
        end else begin
            for (int unsigned i = 0; i < LED_CH; i++)
                if (led_we[i]) led_reg[i] <= merge(led_reg[i], conf_wdata, conf_wen);
            if (wr && addr == 16'h0040) num_reg <= merge(num_reg, conf_wdata, conf_wen);
        end
    end

    always_comb
        for (int unsigned i = 0; i < LED_CH; i++) led[16*i +: 16] = led_reg[i][15:0];

`ifdef CONFREG_TIMER_EN
    logic [31:0] timer;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          timer <= '0;
        else if (wr && addr == 16'h0054)  timer <= merge(timer, conf_wdata, conf_wen);
        else                              timer <= timer + 32'd1;
    end
    assign timer_val = timer;
`else
    assign timer_val = '0;
`endif

    // ---------------- VUART TX FIFO ----------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic        ovf, full, empty, push_req, push_ok, pop, ovf_clr;

    assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
    assign empty    = (cnt == '0);
    assign push_req = wr && addr == 16'h004C && conf_wen[0];
    assign pop      = !empty && uart_tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_clr  = wr && addr == 16'h0050 && conf_wen[2] && conf_wdata[16];

    always_ff @(posedge clk)
        if (push_ok) mem[wp] <= conf_wdata[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            if (push_ok && !pop)      cnt <= cnt + 1'b1;
            else if (!push_ok && pop) cnt <= cnt - 1'b1;
            // Set wins over a simultaneous clear.
            if (push_req && full && !pop) ovf <= 1'b1;
            else if (ovf_clr)             ovf <= 1'b0;
        end
    end

    assign uart_tx_valid = !empty;
    assign uart_tx_data  = empty ? 8'h00 : mem[rp];

    // ---------------- read path ----------------
    logic [31:0] rd_val;
    always_comb begin
        rd_val = '0;
        if (addr[15:6] == 10'd0 && addr[1:0] == 2'd0)
            for (int unsigned i = 0; i < LED_CH; i++)
                if (addr[5:2] == 4'(i)) rd_val = led_reg[i];
        case (addr)
            16'h0040: rd_val = num_reg;
            16'h0044: rd_val = {24'd0, switch};
            16'h0048: rd_val = {24'd0, switch_dip};
            16'h0050: rd_val = {15'd0, ovf, 8'(cnt), 6'd0, full, empty};
            16'h0054: rd_val = timer_val;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          conf_rdata <= '0;
        else if (conf_en) conf_rdata <= rd_val;
    end

    // ---------------- seven-segment scan ----------------
    logic [SW-1:0] scan_cnt;
    logic [1:0]    dig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            dig      <= 2'd0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig      <= dig + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Outputs are re-registered every cycle from the current digit and
    // register contents, giving the one-cycle lag after a wrap or a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LED_CH; i++) begin
                seg_sel[4*i +: 4] <= 4'b0001;
                seg_a_g[7*i +: 7] <= 7'b1111110;
            end
        end else begin
            for (int unsigned i = 0; i < LED_CH; i++) begin
                seg_sel[4*i +: 4] <= 4'b0001 << dig;
                case (dig)
                    2'd0: seg_a_g[7*i +: 7] <= hex7(led_reg[i][3:0]);
                    2'd1: seg_a_g[7*i +: 7] <= hex7(led_reg[i][7:4]);
                    2'd2: seg_a_g[7*i +: 7] <= hex7(led_reg[i][11:8]);
                    default: seg_a_g[7*i +: 7] <= hex7(led_reg[i][15:12]);
                endcase
            end
        end
    end
endmodule

// File: tb/tb_confreg_mc.sv
module tb_confreg_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        conf_en;
    logic [3:0]  conf_wen;
    logic [31:0] conf_addr, conf_wdata, conf_rdata;
    logic [7:0]  switch, switch_dip;
    logic [31:0] led;
    logic [13:0] seg_a_g;
    logic [7:0]  seg_sel;
    logic        uart_tx_valid, uart_tx_ready;
    logic [7:0]  uart_tx_data;

    confreg_mc #(.LED_CH(2), .FIFO_DEPTH(16), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .conf_en(conf_en), .conf_wen(conf_wen),
        .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(conf_rdata),
        .switch(switch), .switch_dip(switch_dip), .led(led), .seg_a_g(seg_a_g),
        .seg_sel(seg_sel), .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
        .uart_tx_ready(uart_tx_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        conf_en = 1'b1; conf_wen = be; conf_addr = a; conf_wdata = d;
        @(posedge clk); #1;
        conf_en = 1'b0; conf_wen = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        conf_en = 1'b1; conf_wen = 4'd0; conf_addr = a;
        @(posedge clk); #1;
        d = conf_rdata;
        conf_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdata"}, conf_rdata, 32'h0);
        chk({tag, "_led"}, led, 32'h0);
        chk({tag, "_valid"}, {31'd0, uart_tx_valid}, 32'h0);
        chk({tag, "_txdata"}, {24'd0, uart_tx_data}, 32'h0);
        chk({tag, "_seg_sel"}, {24'd0, seg_sel}, 32'h11);
        chk({tag, "_seg_a_g"}, {18'd0, seg_a_g}, {18'd0, 7'b1111110, 7'b1111110});
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] rd;
        logic [3:0]  prev_sel;
        logic [6:0]  exp0 [4];
        logic [6:0]  exp1 [4];
        bit          synced;

        vecs[0] = '{"led1_reset",  32'h0004, 4'b0000, 32'h0,        32'h0};
        vecs[1] = '{"led1_bytes",  32'h0004, 4'b0101, 32'hAABBCCDD, 32'h00BB00DD};
        vecs[2] = '{"led0_full",   32'h0000, 4'b1111, 32'h000012A8, 32'h000012A8};
        vecs[3] = '{"num_upper",   32'h0040, 4'b1100, 32'h12345678, 32'h12340000};
        vecs[4] = '{"switch_ro",   32'h0044, 4'b1111, 32'hFFFFFFFF, 32'h0000005A};
        vecs[5] = '{"dip_ro",      32'h0048, 4'b0000, 32'h0,        32'h000000C3};
        vecs[6] = '{"led2_absent", 32'h0008, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[7] = '{"unmapped",    32'h0060, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[8] = '{"stat_idle",   32'h0050, 4'b0000, 32'h0,        32'h00000001};
        vecs[9] = '{"vuart_rd",    32'h004C, 4'b0000, 32'h0,        32'h0};

        rst = 1'b1; conf_en = 1'b0; conf_wen = 4'd0; conf_addr = '0; conf_wdata = '0;
        switch = 8'h5A; switch_dip = 8'hC3; uart_tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wen != 4'd0) bus_write(vecs[v].addr, vecs[v].wen, vecs[v].wdata);
            bus_read(vecs[v].addr, rd);
            chk(vecs[v].name, rd, vecs[v].exp);
        end
        chk("led_out", led, 32'h00DD12A8);

        // Write loads pre-write value, then new value reads back; rdata holds while idle.
        bus_write(32'h0040, 4'b1111, 32'hCAFEF00D);
        chk("rw_same_cycle", conf_rdata, 32'h12340000);
        bus_read(32'h0040, rd);
        chk("num_readback", rd, 32'hCAFEF00D);
        repeat (3) @(posedge clk);
        #1;
        chk("rdata_hold", conf_rdata, 32'hCAFEF00D);

        // Scan: ch0 = 0x12A8 -> 8,A,2,1 ; ch1 = 0x00DD -> D,D,0,0
        exp0[0] = 7'b1111111; exp0[1] = 7'b1110111; exp0[2] = 7'b1101101; exp0[3] = 7'b0110000;
        exp1[0] = 7'b0111101; exp1[1] = 7'b0111101; exp1[2] = 7'b1111110; exp1[3] = 7'b1111110;
        synced = 1'b0;
        prev_sel = seg_sel[3:0];
        for (int c = 0; c < 40 && !synced; c++) begin
            @(posedge clk); #1;
            if (seg_sel[3:0] == 4'b0001 && prev_sel == 4'b1000) synced = 1'b1;
            prev_sel = seg_sel[3:0];
        end
        chk("scan_sync", {28'd0, seg_sel[3:0]}, 32'h1);
        for (int k = 0; k < 16; k++) begin
            chk("scan_sel0", {28'd0, seg_sel[3:0]}, 32'(4'b0001 << (k / 4)));
            chk("scan_sel1", {28'd0, seg_sel[7:4]}, 32'(4'b0001 << (k / 4)));
            chk("scan_seg0", {25'd0, seg_a_g[6:0]}, {25'd0, exp0[k / 4]});
            chk("scan_seg1", {25'd0, seg_a_g[13:7]}, {25'd0, exp1[k / 4]});
            @(posedge clk); #1;
        end

        // FIFO fill past full, then drain.
        for (int b = 1; b <= 17; b++) bus_write(32'h004C, 4'b0001, 32'(b));
        bus_read(32'h0050, rd);
        chk("stat_full_ovf", rd, 32'h00011002);
        uart_tx_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("drain_valid", {31'd0, uart_tx_valid}, 32'h1);
            chk("drain_data", {24'd0, uart_tx_data}, 32'(j + 1));
            @(posedge clk); #1;
        end
        chk("drain_empty", {31'd0, uart_tx_valid}, 32'h0);
        uart_tx_ready = 1'b0;
        bus_read(32'h0050, rd);
        chk("stat_empty_ovf", rd, 32'h00010001);
        bus_write(32'h0050, 4'b0100, 32'h00010000);
        bus_read(32'h0050, rd);
        chk("stat_ovf_clr", rd, 32'h00000001);

        // Push while full with a simultaneous pop.
        for (int b = 0; b < 16; b++) bus_write(32'h004C, 4'b0001, 32'hA0 + 32'(b));
        conf_en = 1'b1; conf_wen = 4'b0001; conf_addr = 32'h004C; conf_wdata = 32'h55;
        uart_tx_ready = 1'b1;
        @(posedge clk); #1;
        conf_en = 1'b0; conf_wen = 4'd0; uart_tx_ready = 1'b0;
        bus_read(32'h0050, rd);
        chk("stat_pushpop_full", rd, 32'h00001002);
        uart_tx_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("pp_data", {24'd0, uart_tx_data}, (j < 15) ? 32'hA1 + 32'(j) : 32'h55);
            @(posedge clk); #1;
        end
        chk("pp_empty", {31'd0, uart_tx_valid}, 32'h0);
        uart_tx_ready = 1'b0;

        // Timer
        bus_write(32'h0054, 4'b1111, 32'hFFFFFFFE);
`ifdef CONFREG_TIMER_EN
        @(posedge clk); #1;
`endif
        conf_en = 1'b1; conf_wen = 4'd0; conf_addr = 32'h0054;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
`ifdef CONFREG_TIMER_EN
            chk("timer", conf_rdata, 32'hFFFFFFFF + 32'(k));
`else
            chk("timer_absent", conf_rdata, 32'h0);
`endif
        end
        conf_en = 1'b0;

        // Asynchronous reset mid-cycle with FIFO contents and nonzero state.
        bus_write(32'h004C, 4'b0001, 32'h77);
        bus_write(32'h004C, 4'b0001, 32'h78);
        bus_read(32'h0048, rd);
        chk("pre_reset_valid", {31'd0, uart_tx_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        bus_read(32'h0050, rd);
        chk("stat_after_reset", rd, 32'h00000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
